// File: rtl/ieee754_normalizer_if.sv
// ieee754_normalizer_if
//   Handshake bundle between the adder core (producer), the normalizer and the
//   result consumer.
//   Input channel : in_valid, in_ready, in_sign, in_exp[9:0] (signed biased),
//                   in_frac[31:0] (carry, hidden, 23 mantissa, guard, 6 sticky)
//   Output channel: out_valid, out_ready, out_float[31:0],
//                   out_flags[3:0] = {overflow, underflow, inexact, zero}
//   slave  modport: the normalizer's view.
//   master modport: the environment's view (producer and consumer together).
interface ieee754_normalizer_if;
    logic               in_valid;
    logic               in_ready;
    logic               in_sign;
    logic signed [9:0]  in_exp;
    logic [31:0]        in_frac;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_float;
    logic [3:0]         out_flags;

    modport slave (
        input  in_valid, in_sign, in_exp, in_frac, out_ready,
        output in_ready, out_valid, out_float, out_flags
    );

    modport master (
        output in_valid, in_sign, in_exp, in_frac, out_ready,
        input  in_ready, out_valid, out_float, out_flags
    );
endinterface

// File: rtl/ieee754_normalizer.sv
// ieee754_normalizer
//   Sequential back end of the single-precision adder. Accepts an unnormalized
//   sign / exponent / extended-fraction triple, normalizes it one bit per cycle,
//   rounds to nearest-even and packs an IEEE754 word with status flags.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - slave side of ieee754_normalizer_if (input triple with
//             valid/ready, packed result and flags with valid/ready)
module ieee754_normalizer #(
    parameter int BIAS = 127
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ieee754_normalizer_if.slave    bus
);

    localparam logic signed [10:0] EMAX = 11'(2 * BIAS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state;
    logic               sign_r;
    logic signed [10:0] exp_r;
    logic [31:0]        frac_r;
    logic [31:0]        frac_shr;

    // Round-to-nearest-even and pack. Returns {float[31:0], ovf, unf, inx, zero}.
    function automatic logic [35:0] round_pack(
        input logic               sgn,
        input logic signed [10:0] e,
        input logic [31:0]        f
    );
        logic [23:0]        m;
        logic [24:0]        m_inc;
        logic               g;
        logic               s;
        logic               up;
        logic signed [10:0] e_rnd;
        logic [7:0]         field;
        logic [22:0]        mant;
        logic               ovf;
        logic               inx;
        logic               unf;
        logic               zro;
        m     = f[30:7];
        g     = f[6];
        s     = |f[5:0];
        up    = g & (s | m[0]);
        m_inc = {1'b0, m} + {24'd0, up};
        e_rnd = e;
        if (m_inc[24]) begin
            m     = m_inc[24:1];
            e_rnd = e + 11'sd1;
        end else begin
            m     = m_inc[23:0];
        end
        // Without the hidden bit the value is subnormal (exponent register
        // sits at 1 then), so the field encodes as 0; a subnormal that
        // rounds up into bit 23 naturally becomes the minimum normal.
        field = m[23] ? e_rnd[7:0] : 8'd0;
        mant  = m[22:0];
        ovf   = m[23] && (e_rnd >= EMAX);
        if (ovf) begin
            field = 8'hFF;
            mant  = 23'd0;
        end
        inx = g | s | ovf;
        unf = (field == 8'd0) && inx;
        zro = (field == 8'd0) && (mant == 23'd0);
        return {sgn, field, mant, ovf, unf, inx, zro};
    endfunction

    // Right shift keeps everything shifted out as a sticky bit in frac[0].
    assign frac_shr     = {1'b0, frac_r[31:2], frac_r[1] | frac_r[0]};
    assign bus.in_ready = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sign_r        <= 1'b0;
            exp_r         <= 11'sd0;
            frac_r        <= 32'd0;
            bus.out_valid <= 1'b0;
            bus.out_float <= 32'd0;
            bus.out_flags <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        sign_r <= bus.in_sign;
                        exp_r  <= {bus.in_exp[9], bus.in_exp};
                        frac_r <= bus.in_frac;
                        state  <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (frac_r == 32'd0) begin
                        state <= ST_ROUND;
                    end else if (frac_r[31] || (exp_r < 11'sd1)) begin
                        frac_r <= frac_shr;
                        // Once only sticky remains further shifts change
                        // nothing; jump the exponent to 1 to bound latency.
                        if (frac_shr[31:1] == 31'd0)
                            exp_r <= 11'sd1;
                        else
                            exp_r <= exp_r + 11'sd1;
                    end else if (!frac_r[30] && (exp_r > 11'sd1)) begin
                        frac_r <= {frac_r[30:0], 1'b0};
                        exp_r  <= exp_r - 11'sd1;
                    end else begin
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    {bus.out_float, bus.out_flags} <= round_pack(sign_r, exp_r, frac_r);
                    bus.out_valid <= 1'b1;
                    state         <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ieee754_normalizer.sv
// tb_ieee754_normalizer
//   Directed bench for ieee754_normalizer: expected words are queued when an
//   operand is driven and popped when the result appears.
module tb_ieee754_normalizer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct packed {
        logic [31:0] f;
        logic [3:0]  fl;
    } exp_t;

    exp_t sb[$];

    ieee754_normalizer_if bus();

    ieee754_normalizer #(.BIAS(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one operand; returns one time unit after the acceptance edge.
    task automatic send(input logic s, input logic [9:0] e, input logic [31:0] f,
                        input bit push, input logic [31:0] ef, input logic [3:0] efl);
        exp_t item;
        @(negedge clk);
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_frac  = f;
        bus.in_valid = 1'b1;
        if (push) begin
            item.f  = ef;
            item.fl = efl;
            sb.push_back(item);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_frac  = 32'hDEAD_BEEF;
        bus.in_exp   = 10'h155;
    endtask

    // Wait for out_valid (bounded), check latency and scoreboard entry.
    task automatic wait_result(input string tag, input int lat);
        int   n;
        exp_t item;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        if (lat >= 0) check({tag, "_latency"}, 32'(n), 32'(lat));
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            item = sb.pop_front();
            check({tag, "_float"}, bus.out_float, item.f);
            check({tag, "_flags"}, 32'(bus.out_flags), 32'(item.fl));
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic s, input logic [9:0] e,
                       input logic [31:0] f, input logic [31:0] ef,
                       input logic [3:0] efl, input int lat);
        send(s, e, f, 1'b1, ef, efl);
        wait_result(tag, lat);
        release_result(tag);
    endtask

    initial begin
        bit seen;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = 10'd0;
        bus.in_frac   = 32'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_float", bus.out_float, 32'd0);
        check("rst_out_flags", 32'(bus.out_flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // flags = {overflow, underflow, inexact, zero}
        run("one",       1'b0, 10'd127, 32'h4000_0000, 32'h3F80_0000, 4'b0000, 2);
        run("carry",     1'b0, 10'd127, 32'h8000_0000, 32'h4000_0000, 4'b0000, 3);
        run("lshift23",  1'b0, 10'd130, 32'h0000_0080, 32'h3580_0000, 4'b0000, 25);
        run("rne_tie",   1'b0, 10'd127, 32'h4000_0040, 32'h3F80_0000, 4'b0010, 2);
        run("rne_up",    1'b0, 10'd127, 32'h4000_00C0, 32'h3F80_0002, 4'b0010, 2);
        run("rne_carry", 1'b0, 10'd127, 32'h7FFF_FFC0, 32'h4000_0000, 4'b0010, 2);
        run("overflow",  1'b1, 10'd254, 32'h8000_0000, 32'hFF80_0000, 4'b1010, 3);
        run("subnorm",   1'b0, 10'd0,   32'h4000_0000, 32'h0040_0000, 4'b0000, 3);
        run("tiny",      1'b0, 10'h3D8, 32'h4000_0001, 32'h0000_0000, 4'b0111, -1);
        run("negzero",   1'b1, 10'd0,   32'h0000_0000, 32'h8000_0000, 4'b0001, 2);
        run("big_exp",   1'b0, 10'd300, 32'h4000_0000, 32'h7F80_0000, 4'b1010, 2);

        // Back-pressure: result held, second operand ignored.
        send(1'b0, 10'd127, 32'h4000_0000, 1'b1, 32'h3F80_0000, 4'b0000);
        wait_result("hold", 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_sign  = 1'b1;
            bus.in_exp   = 10'd100;
            bus.in_frac  = 32'h4000_0000;
            @(posedge clk);
            #1;
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_float", bus.out_float, 32'h3F80_0000);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        release_result("hold");
        repeat (6) @(posedge clk);
        #1;
        check("ignored_no_valid", 32'(bus.out_valid), 32'd0);
        check("ignored_idle", 32'(bus.in_ready), 32'd1);

        // Reset during NORM aborts the operation.
        send(1'b0, 10'd130, 32'h0000_0080, 1'b0, 32'd0, 4'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_out_float", bus.out_float, 32'd0);
        check("abort_out_flags", 32'(bus.out_flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);

        // Normal operation after the abort.
        run("post_rst", 1'b0, 10'd127, 32'h8000_0000, 32'h4000_0000, 4'b0000, 3);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ieee754_normalizer.md
Name: ieee754_normalizer

Overview:
- Sequential back end of the Add32F datapath.
- Takes an unnormalized sign/exponent/extended-fraction triple produced after alignment and add/subtract, normalizes it iteratively (one bit shift per cycle), rounds to nearest-even, and packs a single-precision IEEE754 word with status flags.
- Valid/ready handshakes on both sides, so it can sit between the adder core and any result consumer.

Parameters:
- BIAS, 127, exponent bias used for packing and overflow limit (EMAX = 2*BIAS+1 = 255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input triple valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_sign  in  1  result sign.
- in_exp  in  10  signed two's-complement biased exponent of in_frac.
- in_frac  in  32  unsigned magnitude.
  - Bit 31 = carry, bit 30 = hidden one, bits 29:7 = mantissa, bit 6 = guard, bits 5:0 = sticky.
  - Value = in_frac/2^30 * 2^(in_exp-BIAS).
- out_valid  out  1  result valid, held until accepted.
- out_ready  in  1  consumer accepts result.
- out_float  out  32  packed IEEE754 result.
- out_flags  out  4  {overflow, underflow, inexact, zero}.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; in_ready = 1; out_valid = 0; out_float = 0; out_flags = 0; internal registers cleared.
- Internal exponent register: 11-bit signed, sign-extended from in_exp, so no wrap on +1.
- States: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready, capture sign/exp/frac and go to NORM.
- NORM: one action per cycle, priority order:
  1. frac == 0 → ROUND (zero result).
  2. frac[31] == 1, or exp < 1:
     - Shift right 1 bit; OR the shifted-out bit into frac[0] (sticky); exp += 1.
     - If frac[31:1] == 0 after the shift, set exp = 1 in the same cycle (bounded latency).
  3. frac[30] == 0 and exp > 1 → shift left 1 bit, exp -= 1.
  4. Otherwise → ROUND.
- Latency: out_valid rises on the (k+2)th rising edge after the acceptance edge, where k = number of shift cycles. Maximum k is about 31.
- ROUND: one cycle.
  - m = frac[30:7] (24 bits), g = frac[6], s = |frac[5:0].
  - Round up iff g & (s | m[0]); m += 1.
  - If the increment carries to 25 bits: m >>= 1, exp += 1.
  - Exponent field = m[23] ? exp[7:0] : 0. This covers subnormal results and a subnormal rounding up to the minimum normal.
  - If m[23] & exp ≥ EMAX: result = ±infinity (field 255, mantissa 0).
  - Zero case: result = {sign, 31'b0}; the sign is preserved.
  - Register out_float and out_flags, then go to DONE.
- Flags:
  - inexact = g | s, or overflow.
  - overflow = infinity generated.
  - underflow = field 0 after rounding & inexact.
  - zero = output magnitude 0.
- DONE: out_valid = 1; out_float and out_flags stable.
  - On out_ready: out_valid drops next edge; go to IDLE; in_ready = 1 that edge.
  - No bypass: a new input is accepted no earlier than the cycle after the result is taken.
- in_valid is ignored outside IDLE. in_frac/in_exp may change freely after capture.
- Reset asserted mid-operation aborts immediately; the in-flight result is discarded and never presented.
- Input exponent ≥ EMAX with nonzero frac overflows to infinity via the normal path.
- NaN and infinity inputs are not handled here; upstream bypasses them.

Test Plan:
- sign 0, exp 127, frac 0x4000_0000 → out_float 0x3F80_0000, flags 0000, out_valid 2 edges after accept.
- sign 0, exp 127, frac 0x8000_0000 → 0x4000_0000 (one right shift), out_valid at 3 edges. exp 130, frac 0x0000_0080 → 0x3580_0000 after 23 left shifts (25 edges).
- RNE:
  - frac 0x4000_0040, exp 127 → 0x3F80_0000, inexact = 1 (tie to even).
  - frac 0x4000_00C0 → 0x3F80_0002, inexact = 1.
  - frac 0x7FFF_FFC0, exp 127 → 0x4000_0000 (mantissa carry bumps exponent).
- Overflow: sign 1, exp 254, frac 0x8000_0000 → 0xFF80_0000, overflow = 1, inexact = 1.
- Subnormal and zero:
  - exp 0, frac 0x4000_0000 → 0x0040_0000, underflow = 0 (exact).
  - exp −40, frac 0x4000_0001 → 0x0000_0000, underflow = 1, zero = 1.
  - sign 1, frac 0 → 0x8000_0000, zero = 1.
- Handshake and reset:
  - Hold out_ready low 10 cycles → out_valid and out_float stable, in_ready = 0, a second in_valid is ignored.
  - Release out_ready → in_ready = 1 the next cycle.
  - Pulse rst_n low during NORM → outputs return to reset values immediately, no out_valid pulse.
